// File: rtl/v_red_unit.sv
// v_red_unit: sequential vector reduction, one element per RUN cycle (VREDSUM; VREDMAX optional).
// Build option: define V_RED_MAX_EN to include signed-max reduction; without it op=2 is illegal.
module v_red_unit #(
  parameter int VLEN = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [1:0]              sew,
  input  logic [$clog2(VLEN/8):0] vl,
  input  logic [VLEN-1:0]         vs2,
  input  logic [31:0]             vs1_0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             result,
  output logic                    illegal
);
  localparam int NE = VLEN / 8;
  localparam int IW = $clog2(NE);
  localparam int VW = IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     sew_reg, sew_next;
  logic [VLEN-1:0] vs2_reg, vs2_next;
  logic [VW-1:0]  vl_eff_reg, vl_eff_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [31:0]    acc_reg, acc_next;
  logic           illegal_reg, illegal_next;

  logic           req_legal;
  logic [VW-1:0]  max_elems;
  logic [VW-1:0]  vl_clamped;
  logic [31:0]    elem;
  logic [31:0]    sum_val;
  logic [31:0]    acc_upd;
  logic [31:0]    elem_tbl [NE];

  function automatic logic [31:0] sew_mask(input logic [1:0] s);
    case (s)
      2'd0:    sew_mask = 32'h0000_00ff;
      2'd1:    sew_mask = 32'h0000_ffff;
      default: sew_mask = 32'hffff_ffff;
    endcase
  endfunction

  // Per-index element view for every element width; idx selects from the active width.
  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_elem
      logic [31:0] w16;
      logic [31:0] w32;
      if (gi < NE / 2) begin : g_w16
        assign w16 = {16'd0, vs2_reg[gi*16 +: 16]};
      end else begin : g_w16_z
        assign w16 = '0;
      end
      if (gi < NE / 4) begin : g_w32
        assign w32 = vs2_reg[gi*32 +: 32];
      end else begin : g_w32_z
        assign w32 = '0;
      end
      assign elem_tbl[gi] = (sew_reg == 2'd0) ? {24'd0, vs2_reg[gi*8 +: 8]} :
                            (sew_reg == 2'd1) ? w16 : w32;
    end
  endgenerate

  assign elem    = elem_tbl[idx_reg];
  assign sum_val = (acc_reg + elem) & sew_mask(sew_reg);

`ifdef V_RED_MAX_EN
  logic max_sel_reg, max_sel_next;
  logic [31:0] max_val;

  function automatic logic signed [31:0] sext(input logic [31:0] v, input logic [1:0] s);
    case (s)
      2'd0:    sext = {{24{v[7]}}, v[7:0]};
      2'd1:    sext = {{16{v[15]}}, v[15:0]};
      default: sext = v;
    endcase
  endfunction

  assign max_val   = (sext(elem, sew_reg) > sext(acc_reg, sew_reg)) ? elem : acc_reg;
  assign acc_upd   = max_sel_reg ? max_val : sum_val;
  assign req_legal = (sew != 2'd3) && ((op == 3'd1) || (op == 3'd2));
  assign max_sel_next = (state_reg == IDLE && in_valid) ? (op == 3'd2) : max_sel_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_sel_reg <= 1'b0;
    else     max_sel_reg <= max_sel_next;
  end
`else
  assign acc_upd   = sum_val;
  assign req_legal = (sew != 2'd3) && (op == 3'd1);
`endif

  always_comb begin
    case (sew)
      2'd0:    max_elems = VW'(NE);
      2'd1:    max_elems = VW'(NE / 2);
      default: max_elems = VW'(NE / 4);
    endcase
    vl_clamped = (vl < max_elems) ? vl : max_elems;
  end

  always_comb begin
    state_next   = state_reg;
    sew_next     = sew_reg;
    vs2_next     = vs2_reg;
    vl_eff_next  = vl_eff_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sew_next     = sew;
          vs2_next     = vs2;
          vl_eff_next  = req_legal ? vl_clamped : '0;
          idx_next     = '0;
          illegal_next = !req_legal;
          acc_next     = req_legal ? (vs1_0 & sew_mask(sew)) : 32'd0;
          state_next   = (req_legal && vl_clamped != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_next = acc_upd;
        idx_next = idx_reg + 1'b1;
        if ({1'b0, idx_reg} == vl_eff_reg - 1'b1) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sew_reg     <= 2'd0;
      vs2_reg     <= '0;
      vl_eff_reg  <= '0;
      idx_reg     <= '0;
      acc_reg     <= 32'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sew_reg     <= sew_next;
      vs2_reg     <= vs2_next;
      vl_eff_reg  <= vl_eff_next;
      idx_reg     <= idx_next;
      acc_reg     <= acc_next;
      illegal_reg <= illegal_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = acc_reg;
  assign illegal   = illegal_reg;

endmodule

// File: doc/v_red_unit.md
V_RED_UNIT -- requirements
Module: v_red_unit

Interface
REQ-001 SHALL have parameter VLEN, default 128, meaning the vector register width in bits (multiple of 32).
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  reduction request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  vred_op encoding: 1=VREDSUM, 2=VREDMAX.
REQ-007 SHALL have port sew  input  2  vsew encoding: 0=8b, 1=16b, 2=32b, 3=invalid.
REQ-008 SHALL have port vl  input  $clog2(VLEN/8)+1  requested element count.
REQ-009 SHALL have port vs2  input  VLEN  source vector; element i at bits [i*SEW +: SEW].
REQ-010 SHALL have port vs1_0  input  32  scalar seed; low SEW bits used.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  32  reduction result, SEW bits, upper bits zero.
REQ-014 SHALL have port illegal  output  1  qualifies result; request unsupported.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept a request in cycle T when in_valid&&in_ready, latching op, sew, vs2, vs1_0 and vl_eff=min(vl, VLEN/SEW).
REQ-017 SHALL on acceptance set acc=vs1_0[SEW-1:0], idx=0; go RUN if vl_eff>0 and request legal, else DONE.
REQ-018 SHALL in each RUN cycle set acc=f(acc, elem[idx]), idx=idx+1; after processing idx=vl_eff-1 go DONE.
REQ-019 SHALL for VREDSUM compute acc+elem modulo 2^SEW (wrap, no saturation).
REQ-020 SHALL for VREDMAX compute the signed SEW-bit maximum of acc and elem.
REQ-021 SHALL assert out_valid in cycle T+1+vl_eff (vl_eff=0 for illegal requests).
REQ-022 SHALL hold result, illegal and out_valid stable in DONE until out_ready=1, then return to IDLE next cycle.
REQ-023 SHALL ignore in_valid while not IDLE; no request is dropped or queued.
REQ-024 SHALL flag illegal=1 and result=0 for sew=3 or op not in {1,2}.
REQ-025 SHALL for vl=0 (legal) return vs1_0[SEW-1:0] with illegal=0.

Reset
REQ-026 SHALL on rst=1 immediately enter IDLE: in_ready=1, out_valid=0, result=0, illegal=0, acc=0, idx=0.
REQ-027 SHALL abort any RUN/DONE operation on reset with no result produced.

Configuration
REQ-028 SHALL compile VREDMAX support only when macro V_RED_MAX_EN is defined.
REQ-029 SHALL with V_RED_MAX_EN defined behave per REQ-020.
REQ-030 SHALL without V_RED_MAX_EN treat op=2 as illegal per REQ-024 and contain no comparator logic.

Verification
REQ-031 SHALL cover: VREDSUM sew=0, vs1_0=0xFF, vs2 elems {0x01,0x01}, vl=2 -> result=0x01 at T+3, illegal=0.
REQ-032 SHALL cover: VREDMAX sew=1, vs1_0=0xFFFF, elems {0x8000,0x7FFF,0x0001}, vl=3 -> result=0x7FFF at T+4.
REQ-033 SHALL cover: VREDSUM sew=2, vl=0, vs1_0=0x12345678 -> result=0x12345678 at T+1; vl=9 at VLEN=128 clamps to 4 elements.
REQ-034 SHALL cover: out_ready low 5 cycles in DONE -> result/out_valid held, in_ready=0, new in_valid ignored.
REQ-035 SHALL cover: rst pulsed mid-RUN -> out_valid never asserts, in_ready=1 immediately; sew=3 -> illegal=1, result=0 at T+1.
REQ-036 SHALL cover: without V_RED_MAX_EN, op=2 sew=0 vl=4 -> illegal=1, result=0 at T+1.
